// File: rtl/reli_sync_fifo.sv
// Single-clock FIFO with std/FWFT read modes, synchronous flush and a
// high-watermark occupancy monitor, buffering NACK commands ahead of the packet builder.
module reli_sync_fifo #(
    parameter int    DATA_WIDTH        = 16,
    parameter int    DEPTH             = 2048,
    parameter string READ_MODE         = "fwft",
    parameter int    PROG_FULL_THRESH  = 2000,
    parameter int    PROG_EMPTY_THRESH = 10,
    parameter int    CNT_WIDTH         = $clog2(DEPTH) + 1
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  max_count_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  prog_empty,
    output logic                  prog_full,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CNT_WIDTH-1:0]  data_count,
    output logic [CNT_WIDTH-1:0]  max_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam bit FWFT = (READ_MODE == "fwft");

    localparam logic [CNT_WIDTH-1:0] C_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH1 = CNT_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] C_PFULL  = CNT_WIDTH'(PROG_FULL_THRESH);
    localparam logic [CNT_WIDTH-1:0] C_PEMPTY = CNT_WIDTH'(PROG_EMPTY_THRESH);

    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("reli_sync_fifo: DEPTH must be a power of two and at least 16");
    end
    if (!(PROG_EMPTY_THRESH >= 1 && PROG_EMPTY_THRESH < PROG_FULL_THRESH &&
          PROG_FULL_THRESH < DEPTH)) begin : g_bad_thresh
        $error("reli_sync_fifo: need 1 <= PROG_EMPTY_THRESH < PROG_FULL_THRESH < DEPTH");
    end
    if (READ_MODE != "std" && READ_MODE != "fwft") begin : g_bad_mode
        $error("reli_sync_fifo: READ_MODE must be \"std\" or \"fwft\"");
    end
    if (CNT_WIDTH < $clog2(DEPTH) + 1) begin : g_bad_cnt
        $error("reli_sync_fifo: CNT_WIDTH too narrow to hold DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  max_q, max_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  pempty_q, pempty_d;
    logic                  pfull_q, pfull_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_has_word;
    logic                  ram_rd;

    function automatic logic [CNT_WIDTH-1:0] peak(input logic [CNT_WIDTH-1:0] cur,
                                                  input logic [CNT_WIDTH-1:0] hold);
        return (cur > hold) ? cur : hold;
    endfunction

    // Request acceptance is judged on start-of-cycle flags only.
    always_comb begin
        wr_acc       = wr_en && !full_q && !flush;
        rd_acc       = rd_en && !empty_q && !flush;
        // In fwft the output stage is part of count; RAM holds the remainder.
        ram_has_word = (count_q != CNT_WIDTH'(valid_q));
        if (FWFT) begin
            ram_rd = !flush && ram_has_word && (!valid_q || rd_acc);
        end else begin
            ram_rd = rd_acc;
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        dout_d   = dout_q;

        if (flush) begin
            count_d  = C_ZERO;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            valid_d  = 1'b0;
        end else begin
            if (wr_acc && !rd_acc) begin
                count_d = count_q + C_ONE;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - C_ONE;
            end
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (ram_rd) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem[rd_ptr_q];
            end
            if (FWFT) begin
                if (ram_rd) begin
                    valid_d = 1'b1;
                end else if (rd_acc) begin
                    valid_d = 1'b0;
                end
            end else begin
                valid_d = rd_acc;
            end
        end

        full_d   = (count_d == C_DEPTH);
        afull_d  = (count_d >= C_DEPTH1);
        pfull_d  = (count_d >= C_PFULL);
        aempty_d = (count_d <= C_ONE);
        pempty_d = (count_d <= C_PEMPTY);
        empty_d  = FWFT ? !valid_d : (count_d == C_ZERO);

        wr_ack_d = wr_acc;
        ovf_d    = wr_en && full_q && !flush;
        unf_d    = rd_en && empty_q && !flush;

        max_d    = max_count_clr ? count_q : peak(count_q, max_q);
    end

    always_ff @(posedge wr_clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Registered stage: every output comes straight from a flop.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            pempty_q <= 1'b1;
            pfull_q  <= 1'b0;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            pempty_q <= pempty_d;
            pfull_q  <= pfull_d;
            wr_ack_q <= wr_ack_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign dout         = dout_q;
    assign data_valid   = valid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign prog_empty   = pempty_q;
    assign prog_full    = pfull_q;
    assign wr_ack       = wr_ack_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_count   = count_q;
    assign max_count    = max_q;

endmodule

// File: tb/tb_reli_sync_fifo.sv
// Self-checking bench: one std-mode and one fwft-mode FIFO (DEPTH=16) driven by shared stimulus.
module tb_reli_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        flush = 1'b0;
    logic        mclr = 1'b0;
    logic [15:0] din = '0;

    logic [15:0] dout_s, dout_f;
    logic        dv_s, dv_f, emp_s, emp_f, ful_s, ful_f, ae_s, ae_f, af_s, af_f;
    logic        pe_s, pe_f, pf_s, pf_f, ack_s, ack_f, ovf_s, ovf_f, unf_s, unf_f;
    logic [4:0]  cnt_s, cnt_f, max_s, max_f;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] q_s[$];
    logic [15:0] q_f[$];
    logic [15:0] e;

    reli_sync_fifo #(.DATA_WIDTH(16), .DEPTH(16), .READ_MODE("std"),
                     .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) u_std (
        .wr_clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .max_count_clr(mclr), .dout(dout_s), .data_valid(dv_s),
        .empty(emp_s), .full(ful_s), .almost_empty(ae_s), .almost_full(af_s),
        .prog_empty(pe_s), .prog_full(pf_s), .wr_ack(ack_s), .overflow(ovf_s),
        .underflow(unf_s), .data_count(cnt_s), .max_count(max_s));

    reli_sync_fifo #(.DATA_WIDTH(16), .DEPTH(16), .READ_MODE("fwft"),
                     .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) u_fwft (
        .wr_clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .max_count_clr(mclr), .dout(dout_f), .data_valid(dv_f),
        .empty(emp_f), .full(ful_f), .almost_empty(ae_f), .almost_full(af_f),
        .prog_empty(pe_f), .prog_full(pf_f), .wr_ack(ack_f), .overflow(ovf_f),
        .underflow(unf_f), .data_count(cnt_f), .max_count(max_f));

    task automatic cyc(input logic w, input logic [15:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        mclr = 1'b0;
        cyc(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        q_s.delete();
        q_f.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        n_vec++; if (emp_s !== 1'b1) begin n_bad++; $display("FAIL rst_empty_s: got %b want 1", emp_s); end
        n_vec++; if (pe_s !== 1'b1) begin n_bad++; $display("FAIL rst_prog_empty_s: got %b want 1", pe_s); end
        n_vec++; if (ae_s !== 1'b1) begin n_bad++; $display("FAIL rst_almost_empty_s: got %b want 1", ae_s); end
        n_vec++; if (ful_s !== 1'b0) begin n_bad++; $display("FAIL rst_full_s: got %b want 0", ful_s); end
        n_vec++; if (cnt_s !== 5'd0) begin n_bad++; $display("FAIL rst_count_s: got %0d want 0", cnt_s); end
        n_vec++; if (max_s !== 5'd0) begin n_bad++; $display("FAIL rst_max_s: got %0d want 0", max_s); end
        n_vec++; if (dout_s !== 16'h0) begin n_bad++; $display("FAIL rst_dout_s: got %h want 0000", dout_s); end
        n_vec++; if (dv_s !== 1'b0) begin n_bad++; $display("FAIL rst_valid_s: got %b want 0", dv_s); end
        n_vec++; if (emp_f !== 1'b1) begin n_bad++; $display("FAIL rst_empty_f: got %b want 1", emp_f); end
        n_vec++; if (dout_f !== 16'h0) begin n_bad++; $display("FAIL rst_dout_f: got %h want 0000", dout_f); end
        rst = 1'b0;
    endtask

    task automatic fill16(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, base + 16'(i), 1'b0);
            q_s.push_back(base + 16'(i));
            q_f.push_back(base + 16'(i));
        end
    endtask

    task automatic test_fill_overflow();
        logic ex;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            q_s.push_back(16'(i));
            q_f.push_back(16'(i));
            n_vec++; if (cnt_s !== 5'(i)) begin n_bad++; $display("FAIL fill_count_s: got %0d want %0d", cnt_s, i); end
            n_vec++; if (cnt_f !== 5'(i)) begin n_bad++; $display("FAIL fill_count_f: got %0d want %0d", cnt_f, i); end
            n_vec++; if (ack_s !== 1'b1) begin n_bad++; $display("FAIL fill_ack_s: got %b want 1 at %0d", ack_s, i); end
            ex = (i >= 12);
            n_vec++; if (pf_s !== ex) begin n_bad++; $display("FAIL fill_prog_full_s: got %b want %b at %0d", pf_s, ex, i); end
            ex = (i >= 15);
            n_vec++; if (af_s !== ex) begin n_bad++; $display("FAIL fill_almost_full_s: got %b want %b at %0d", af_s, ex, i); end
            ex = (i == 16);
            n_vec++; if (ful_s !== ex) begin n_bad++; $display("FAIL fill_full_s: got %b want %b at %0d", ful_s, ex, i); end
            n_vec++; if (ful_f !== ex) begin n_bad++; $display("FAIL fill_full_f: got %b want %b at %0d", ful_f, ex, i); end
            ex = (i <= 4);
            n_vec++; if (pe_s !== ex) begin n_bad++; $display("FAIL fill_prog_empty_s: got %b want %b at %0d", pe_s, ex, i); end
            ex = (i <= 1);
            n_vec++; if (ae_s !== ex) begin n_bad++; $display("FAIL fill_almost_empty_s: got %b want %b at %0d", ae_s, ex, i); end
        end
        cyc(1'b1, 16'h0011, 1'b0);
        n_vec++; if (ovf_s !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse_s: got %b want 1", ovf_s); end
        n_vec++; if (ovf_f !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse_f: got %b want 1", ovf_f); end
        n_vec++; if (ack_s !== 1'b0) begin n_bad++; $display("FAIL ovf_ack_s: got %b want 0", ack_s); end
        n_vec++; if (cnt_s !== 5'd16) begin n_bad++; $display("FAIL ovf_count_s: got %0d want 16", cnt_s); end
        cyc(1'b0, 16'h0, 1'b0);
        n_vec++; if (ovf_s !== 1'b0) begin n_bad++; $display("FAIL ovf_single_s: got %b want 0", ovf_s); end
        for (int i = 0; i < 16; i++) begin
            e = q_f.pop_front();
            n_vec++; if (dv_f !== 1'b1 || dout_f !== e) begin n_bad++; $display("FAIL drain16_f: got %b/%h want 1/%h", dv_f, dout_f, e); end
            cyc(1'b0, 16'h0, 1'b1);
            e = q_s.pop_front();
            n_vec++; if (dv_s !== 1'b1 || dout_s !== e) begin n_bad++; $display("FAIL drain16_s: got %b/%h want 1/%h", dv_s, dout_s, e); end
        end
        n_vec++; if (emp_s !== 1'b1 || emp_f !== 1'b1) begin n_bad++; $display("FAIL drain16_empty: got %b/%b want 1/1", emp_s, emp_f); end
    endtask

    task automatic test_fwft_drain();
        do_reset();
        cyc(1'b1, 16'hA5A5, 1'b0);
        n_vec++; if (cnt_f !== 5'd1) begin n_bad++; $display("FAIL fwft_n1_count: got %0d want 1", cnt_f); end
        n_vec++; if (dv_f !== 1'b0 || emp_f !== 1'b1) begin n_bad++; $display("FAIL fwft_n1_notyet: got valid %b empty %b want 0/1", dv_f, emp_f); end
        n_vec++; if (emp_s !== 1'b0 || cnt_s !== 5'd1) begin n_bad++; $display("FAIL std_n1: got empty %b count %0d want 0/1", emp_s, cnt_s); end
        cyc(1'b0, 16'h0, 1'b0);
        n_vec++; if (dv_f !== 1'b1 || dout_f !== 16'hA5A5) begin n_bad++; $display("FAIL fwft_n2_head: got %b/%h want 1/a5a5", dv_f, dout_f); end
        n_vec++; if (emp_f !== 1'b0) begin n_bad++; $display("FAIL fwft_n2_empty: got %b want 0", emp_f); end
        cyc(1'b0, 16'h0, 1'b1);
        n_vec++; if (dv_s !== 1'b1 || dout_s !== 16'hA5A5) begin n_bad++; $display("FAIL std_read_a5: got %b/%h want 1/a5a5", dv_s, dout_s); end
        n_vec++; if (emp_f !== 1'b1 || dv_f !== 1'b0) begin n_bad++; $display("FAIL fwft_consumed: got empty %b valid %b want 1/0", emp_f, dv_f); end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 16'(i * 16'h11), 1'b0);
            q_s.push_back(16'(i * 16'h11));
            q_f.push_back(16'(i * 16'h11));
        end
        cyc(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e = q_f.pop_front();
            n_vec++; if (dv_f !== 1'b1 || dout_f !== e) begin n_bad++; $display("FAIL fwft_burst: got %b/%h want 1/%h", dv_f, dout_f, e); end
            cyc(1'b0, 16'h0, 1'b1);
            e = q_s.pop_front();
            n_vec++; if (dv_s !== 1'b1 || dout_s !== e) begin n_bad++; $display("FAIL std_burst: got %b/%h want 1/%h", dv_s, dout_s, e); end
        end
        n_vec++; if (emp_f !== 1'b1 || emp_s !== 1'b1) begin n_bad++; $display("FAIL burst_empty: got %b/%b want 1/1", emp_f, emp_s); end
        cyc(1'b0, 16'h0, 1'b1);
        n_vec++; if (unf_f !== 1'b1 || unf_s !== 1'b1) begin n_bad++; $display("FAIL underflow: got %b/%b want 1/1", unf_f, unf_s); end
        n_vec++; if (dv_s !== 1'b0) begin n_bad++; $display("FAIL underflow_valid_s: got %b want 0", dv_s); end
        cyc(1'b0, 16'h0, 1'b0);
        n_vec++; if (unf_f !== 1'b0) begin n_bad++; $display("FAIL underflow_single: got %b want 0", unf_f); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill16(16'h0100);
        e = q_f.pop_front();
        n_vec++; if (dout_f !== e) begin n_bad++; $display("FAIL full_rw_head_f: got %h want %h", dout_f, e); end
        cyc(1'b1, 16'hBEEF, 1'b1);
        n_vec++; if (cnt_s !== 5'd15 || cnt_f !== 5'd15) begin n_bad++; $display("FAIL full_rw_count: got %0d/%0d want 15", cnt_s, cnt_f); end
        n_vec++; if (ovf_s !== 1'b1 || ovf_f !== 1'b1) begin n_bad++; $display("FAIL full_rw_ovf: got %b/%b want 1/1", ovf_s, ovf_f); end
        n_vec++; if (ack_s !== 1'b0 || ful_s !== 1'b0) begin n_bad++; $display("FAIL full_rw_ack_full: got %b/%b want 0/0", ack_s, ful_s); end
        e = q_s.pop_front();
        n_vec++; if (dv_s !== 1'b1 || dout_s !== e) begin n_bad++; $display("FAIL full_rw_data_s: got %b/%h want 1/%h", dv_s, dout_s, e); end

        do_reset();
        cyc(1'b1, 16'h0077, 1'b1);
        n_vec++; if (cnt_s !== 5'd1 || cnt_f !== 5'd1) begin n_bad++; $display("FAIL empty_rw_count: got %0d/%0d want 1", cnt_s, cnt_f); end
        n_vec++; if (unf_s !== 1'b1 || unf_f !== 1'b1) begin n_bad++; $display("FAIL empty_rw_unf: got %b/%b want 1/1", unf_s, unf_f); end
        n_vec++; if (ack_s !== 1'b1 || ack_f !== 1'b1) begin n_bad++; $display("FAIL empty_rw_ack: got %b/%b want 1/1", ack_s, ack_f); end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 16'h2000 + 16'(i), 1'b0);
            q_s.push_back(16'h2000 + 16'(i));
            q_f.push_back(16'h2000 + 16'(i));
        end
        for (int i = 0; i < 100; i++) begin
            e = q_f.pop_front();
            n_vec++; if (dv_f !== 1'b1 || dout_f !== e) begin n_bad++; $display("FAIL half_rw_f: cycle %0d got %b/%h want 1/%h", i, dv_f, dout_f, e); end
            q_s.push_back(16'h3000 + 16'(i));
            q_f.push_back(16'h3000 + 16'(i));
            cyc(1'b1, 16'h3000 + 16'(i), 1'b1);
            e = q_s.pop_front();
            n_vec++; if (dv_s !== 1'b1 || dout_s !== e) begin n_bad++; $display("FAIL half_rw_s: cycle %0d got %b/%h want 1/%h", i, dv_s, dout_s, e); end
            n_vec++; if (cnt_s !== 5'd8 || cnt_f !== 5'd8) begin n_bad++; $display("FAIL half_rw_count: cycle %0d got %0d/%0d want 8", i, cnt_s, cnt_f); end
        end
    endtask

    task automatic test_flush_watermark();
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0);
        flush = 1'b1;
        cyc(1'b1, 16'hDEAD, 1'b0);
        flush = 1'b0;
        n_vec++; if (cnt_s !== 5'd0 || cnt_f !== 5'd0) begin n_bad++; $display("FAIL flush_count: got %0d/%0d want 0", cnt_s, cnt_f); end
        n_vec++; if (emp_s !== 1'b1 || emp_f !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b/%b want 1/1", emp_s, emp_f); end
        n_vec++; if (ack_s !== 1'b0 || ack_f !== 1'b0) begin n_bad++; $display("FAIL flush_ack: got %b/%b want 0/0", ack_s, ack_f); end
        n_vec++; if (max_s !== 5'd10 || max_f !== 5'd10) begin n_bad++; $display("FAIL flush_max: got %0d/%0d want 10", max_s, max_f); end
        n_vec++; if (pe_s !== 1'b1 || ae_f !== 1'b1) begin n_bad++; $display("FAIL flush_flags: got %b/%b want 1/1", pe_s, ae_f); end
        n_vec++; if (dv_f !== 1'b0 || dout_f !== 16'h0200) begin n_bad++; $display("FAIL flush_dout_f: got %b/%h want 0/0200", dv_f, dout_f); end
        mclr = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);
        mclr = 1'b0;
        n_vec++; if (max_s !== 5'd0 || max_f !== 5'd0) begin n_bad++; $display("FAIL max_clr: got %0d/%0d want 0", max_s, max_f); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 16'h0400 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0500 + 16'(i), 1'b1);
        rst = 1'b1;
        cyc(1'b1, 16'h0999, 1'b1);
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_vec++; if (emp_s !== 1'b1 || ae_s !== 1'b1 || pe_s !== 1'b1) begin n_bad++; $display("FAIL mid_rst_lowflags_s: got %b%b%b want 111", emp_s, ae_s, pe_s); end
        n_vec++; if (emp_f !== 1'b1 || ae_f !== 1'b1 || pe_f !== 1'b1) begin n_bad++; $display("FAIL mid_rst_lowflags_f: got %b%b%b want 111", emp_f, ae_f, pe_f); end
        n_vec++; if ({ful_s, af_s, pf_s, ack_s, ovf_s, unf_s, dv_s} !== 7'b0) begin n_bad++; $display("FAIL mid_rst_pulses_s: got %b want 0000000", {ful_s, af_s, pf_s, ack_s, ovf_s, unf_s, dv_s}); end
        n_vec++; if ({ful_f, af_f, pf_f, ack_f, ovf_f, unf_f, dv_f} !== 7'b0) begin n_bad++; $display("FAIL mid_rst_pulses_f: got %b want 0000000", {ful_f, af_f, pf_f, ack_f, ovf_f, unf_f, dv_f}); end
        n_vec++; if (cnt_s !== 5'd0 || max_s !== 5'd0 || dout_s !== 16'h0) begin n_bad++; $display("FAIL mid_rst_regs_s: got %0d/%0d/%h want 0/0/0000", cnt_s, max_s, dout_s); end
        n_vec++; if (cnt_f !== 5'd0 || max_f !== 5'd0 || dout_f !== 16'h0) begin n_bad++; $display("FAIL mid_rst_regs_f: got %0d/%0d/%h want 0/0/0000", cnt_f, max_f, dout_f); end
        cyc(1'b1, 16'h005A, 1'b0);
        cyc(1'b1, 16'h0066, 1'b0);
        n_vec++; if (dv_f !== 1'b1 || dout_f !== 16'h005A) begin n_bad++; $display("FAIL mid_rst_first_f: got %b/%h want 1/005a", dv_f, dout_f); end
        cyc(1'b0, 16'h0, 1'b1);
        n_vec++; if (dv_s !== 1'b1 || dout_s !== 16'h005A) begin n_bad++; $display("FAIL mid_rst_first_s: got %b/%h want 1/005a", dv_s, dout_s); end
        n_vec++; if (dout_f !== 16'h0066) begin n_bad++; $display("FAIL mid_rst_second_f: got %h want 0066", dout_f); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_overflow();
        test_fwft_drain();
        test_back_to_back();
        test_flush_watermark();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
